// File: rtl/ghost_position_commit_if.sv
// rtl/ghost_position_commit_if.sv - ghost controller <-> position commit stage link
//
// Purpose: carries the controller's step proposal into the commit stage and
//          the committed position/direction back to the controller.
// Signals:
//   move_tick        one-cycle step request
//   next_x, next_y   proposed pixel position
//   ghost_direction  proposed direction
//   x, y             committed ghost position
//   dir_out          direction of the last committed step
//   blocked          one-cycle pulse when a proposal was rejected
interface ghost_position_commit_if #(
    parameter int XW = 10,
    parameter int YW = 9
);
    logic          move_tick;
    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;
    logic [1:0]    ghost_direction;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [1:0]    dir_out;
    logic          blocked;

    modport master (
        output move_tick, next_x, next_y, ghost_direction,
        input  x, y, dir_out, blocked
    );

    modport slave (
        input  move_tick, next_x, next_y, ghost_direction,
        output x, y, dir_out, blocked
    );
endinterface

// File: rtl/ghost_position_commit.sv
// rtl/ghost_position_commit.sv - validates and commits ghost steps, handles capture and respawn
//
// Purpose: latches a proposed step on move_tick, checks it against tile
//          alignment, playfield bounds and the wall map, commits accepted
//          steps, detects contact with Pac-Man and runs the respawn hold.
// Ports:
//   clk_i, reset_i     clock, synchronous active-high reset
//   mv                 step proposal in / committed position out (slave)
//   pacman_x_i/_y_i    current Pac-Man position
//   tilemap_walls_i    wall bit per tile, index row*COLS+col
//   caught_o           one-cycle pulse on contact
//   respawning_o       high during the respawn hold
//   tick_overrun_o     sticky: a tick arrived while CHECK/COMMIT was busy
module ghost_position_commit #(
    parameter int TILE_SIZE     = 20,
    parameter int COLS          = 32,
    parameter int ROWS          = 24,
    parameter int START_X       = 600,
    parameter int START_Y       = 320,
    parameter int RESPAWN_TICKS = 60,
    parameter int WIDTH         = COLS * TILE_SIZE,
    parameter int HEIGHT        = ROWS * TILE_SIZE
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    ghost_position_commit_if.slave      mv,
    input  logic [$clog2(WIDTH)-1:0]    pacman_x_i,
    input  logic [$clog2(HEIGHT)-1:0]   pacman_y_i,
    input  logic [ROWS*COLS-1:0]        tilemap_walls_i,
    output logic                        caught_o,
    output logic                        respawning_o,
    output logic                        tick_overrun_o
);
    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int IW = $clog2(ROWS * COLS);

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT, S_RESPAWN} state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] prop_x_q, prop_x_d, x_q, x_d;
    logic [YW-1:0] prop_y_q, prop_y_d, y_q, y_d;
    logic [1:0]    prop_dir_q, prop_dir_d, dir_q, dir_d;
    logic          blocked_q, blocked_d;
    logic          caught_q, caught_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    cnt_q, cnt_d;

    // Tile lookup for the latched proposal; constant divisors keep it one cycle.
    logic [XW-1:0] col_c;
    logic [YW-1:0] row_c;
    logic [IW-1:0] tile_idx;
    logic          aligned, in_range, wall_hit, reject, contact;

    always_comb begin
        col_c    = prop_x_q / XW'(TILE_SIZE);
        row_c    = prop_y_q / YW'(TILE_SIZE);
        aligned  = (prop_x_q % XW'(TILE_SIZE) == '0) && (prop_y_q % YW'(TILE_SIZE) == '0);
        in_range = (col_c < XW'(COLS)) && (row_c < YW'(ROWS));
        // Index is only meaningful when in range; the wall bit is masked otherwise.
        tile_idx = IW'(row_c) * IW'(COLS) + IW'(col_c);
        wall_hit = in_range && tilemap_walls_i[tile_idx];
        reject   = !aligned || !in_range || wall_hit;
        contact  = (x_q == pacman_x_i) && (y_q == pacman_y_i);
    end

    always_comb begin
        state_d    = state_q;
        prop_x_d   = prop_x_q;
        prop_y_d   = prop_y_q;
        prop_dir_d = prop_dir_q;
        x_d        = x_q;
        y_d        = y_q;
        dir_d      = dir_q;
        blocked_d  = 1'b0;
        caught_d   = 1'b0;
        overrun_d  = overrun_q;
        cnt_d      = cnt_q;
        case (state_q)
            S_IDLE: begin
                // Contact wins over a same-cycle tick; that tick is simply discarded.
                if (contact) begin
                    caught_d = 1'b1;
                    cnt_d    = 8'(RESPAWN_TICKS);
                    state_d  = S_RESPAWN;
                end else if (mv.move_tick) begin
                    prop_x_d   = mv.next_x;
                    prop_y_d   = mv.next_y;
                    prop_dir_d = mv.ghost_direction;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mv.move_tick) overrun_d = 1'b1;
                if (reject) begin
                    blocked_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (mv.move_tick) overrun_d = 1'b1;
                x_d     = prop_x_q;
                y_d     = prop_y_q;
                dir_d   = prop_dir_q;
                state_d = S_IDLE;
            end
            S_RESPAWN: begin
                if (mv.move_tick) begin
                    if (cnt_q <= 8'd1) begin
                        cnt_d   = 8'd0;
                        x_d     = XW'(START_X);
                        y_d     = YW'(START_Y);
                        dir_d   = DIR_DOWN;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            prop_x_q   <= '0;
            prop_y_q   <= '0;
            prop_dir_q <= DIR_UP;
            x_q        <= XW'(START_X);
            y_q        <= YW'(START_Y);
            dir_q      <= DIR_DOWN;
            blocked_q  <= 1'b0;
            caught_q   <= 1'b0;
            overrun_q  <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            prop_x_q   <= prop_x_d;
            prop_y_q   <= prop_y_d;
            prop_dir_q <= prop_dir_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
            blocked_q  <= blocked_d;
            caught_q   <= caught_d;
            overrun_q  <= overrun_d;
            cnt_q      <= cnt_d;
        end
    end

    assign mv.x           = x_q;
    assign mv.y           = y_q;
    assign mv.dir_out     = dir_q;
    assign mv.blocked     = blocked_q;
    assign caught_o       = caught_q;
    assign respawning_o   = (state_q == S_RESPAWN);
    assign tick_overrun_o = overrun_q;

    // DIR_LEFT/DIR_RIGHT document the encoding; only DIR_UP/DIR_DOWN are used here.
    logic unused_dirs;
    assign unused_dirs = ^{DIR_LEFT, DIR_RIGHT};
endmodule

// File: tb/tb_ghost_position_commit.sv
// tb/tb_ghost_position_commit.sv - directed bench for ghost_position_commit
module tb_ghost_position_commit;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [9:0]   pacman_x;
    logic [8:0]   pacman_y;
    logic [767:0] walls;
    logic         caught, respawning, overrun;
    int passed = 0;
    int total  = 0;

    ghost_position_commit_if #(.XW(10), .YW(9)) mv();

    ghost_position_commit #(.RESPAWN_TICKS(3)) dut (
        .clk_i(clk), .reset_i(reset), .mv(mv),
        .pacman_x_i(pacman_x), .pacman_y_i(pacman_y), .tilemap_walls_i(walls),
        .caught_o(caught), .respawning_o(respawning), .tick_overrun_o(overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; mv.move_tick = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic propose(input logic [9:0] nx, input logic [8:0] ny, input logic [1:0] d);
        mv.move_tick = 1'b1; mv.next_x = nx; mv.next_y = ny; mv.ghost_direction = d;
        step();
        mv.move_tick = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (mv.x !== 10'd600) $display("FAIL reset_x got %0d want 600", mv.x); else passed++;
        total++; if (mv.y !== 9'd320) $display("FAIL reset_y got %0d want 320", mv.y); else passed++;
        total++; if (mv.dir_out !== 2'd1) $display("FAIL reset_dir got %0d want 1", mv.dir_out); else passed++;
        total++; if ({mv.blocked, caught, respawning, overrun} !== 4'b0)
            $display("FAIL reset_flags got %b want 0000", {mv.blocked, caught, respawning, overrun}); else passed++;
    endtask

    task automatic test_accept();
        walls = '0;
        propose(10'd600, 9'd340, 2'd1);  // now T+1
        step();                          // T+2
        total++; if (mv.blocked !== 1'b0) $display("FAIL accept_blocked got %b want 0", mv.blocked); else passed++;
        total++; if (mv.y !== 9'd320) $display("FAIL accept_early got %0d want 320", mv.y); else passed++;
        step();                          // T+3
        total++; if ({mv.x, mv.y} !== {10'd600, 9'd340})
            $display("FAIL accept_xy got %0d,%0d want 600,340", mv.x, mv.y); else passed++;
        total++; if (mv.dir_out !== 2'd1) $display("FAIL accept_dir got %0d want 1", mv.dir_out); else passed++;
    endtask

    task automatic test_wall();
        do_reset();
        walls = '0; walls[574] = 1'b1;
        propose(10'd600, 9'd340, 2'd0);
        step();
        total++; if (mv.blocked !== 1'b1) $display("FAIL wall_blocked got %b want 1", mv.blocked); else passed++;
        step();
        total++; if (mv.blocked !== 1'b0) $display("FAIL wall_pulse got %b want 0", mv.blocked); else passed++;
        total++; if ({mv.x, mv.y, mv.dir_out} !== {10'd600, 9'd320, 2'd1})
            $display("FAIL wall_hold got %0d,%0d,%0d want 600,320,1", mv.x, mv.y, mv.dir_out); else passed++;
        walls = '0;
    endtask

    task automatic test_bounds();
        logic [9:0] xs [3] = '{10'd610, 10'd640, 10'd0};
        logic [8:0] ys [3] = '{9'd320, 9'd320, 9'd480};
        for (int i = 0; i < 3; i++) begin
            propose(xs[i], ys[i], 2'd2);
            step();
            total++; if (mv.blocked !== 1'b1)
                $display("FAIL bounds_%0d got blocked=%b want 1", i, mv.blocked); else passed++;
        end
        step();
        total++; if ({mv.x, mv.y} !== {10'd600, 9'd320})
            $display("FAIL bounds_hold got %0d,%0d want 600,320", mv.x, mv.y); else passed++;
    endtask

    task automatic test_catch_respawn();
        propose(10'd600, 9'd340, 2'd3);
        step(); step();
        total++; if ({mv.y, mv.dir_out} !== {9'd340, 2'd3})
            $display("FAIL catch_setup got %0d,%0d want 340,3", mv.y, mv.dir_out); else passed++;
        pacman_x = 10'd600; pacman_y = 9'd340;
        propose(10'd600, 9'd360, 2'd1);
        pacman_x = 10'd0; pacman_y = 9'd0;
        total++; if ({caught, respawning} !== 2'b11)
            $display("FAIL catch_pulse got %b want 11", {caught, respawning}); else passed++;
        step();
        total++; if ({caught, respawning, overrun} !== 3'b010)
            $display("FAIL catch_after got %b want 010", {caught, respawning, overrun}); else passed++;
        propose(10'd600, 9'd360, 2'd0); step();
        propose(10'd600, 9'd360, 2'd0);
        total++; if ({respawning, mv.y} !== {1'b1, 9'd340})
            $display("FAIL respawn_hold got %b,%0d want 1,340", respawning, mv.y); else passed++;
        propose(10'd600, 9'd360, 2'd0);
        total++; if ({mv.x, mv.y, respawning} !== {10'd600, 9'd320, 1'b0})
            $display("FAIL respawn_home got %0d,%0d,%b want 600,320,0", mv.x, mv.y, respawning); else passed++;
        total++; if (mv.dir_out !== 2'd1) $display("FAIL respawn_dir got %0d want 1", mv.dir_out); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL respawn_overrun got %b want 0", overrun); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        propose(10'd600, 9'd340, 2'd1);  // T+1, dut in CHECK
        propose(10'd600, 9'd400, 2'd0);  // dropped, T+2
        total++; if (overrun !== 1'b1) $display("FAIL overrun_set got %b want 1", overrun); else passed++;
        step();                          // T+3
        total++; if ({mv.y, mv.dir_out} !== {9'd340, 2'd1})
            $display("FAIL overrun_commit got %0d,%0d want 340,1", mv.y, mv.dir_out); else passed++;
        propose(10'd600, 9'd360, 2'd1);  // spacing of 3 from previous accepted tick
        step(); step();
        total++; if (mv.y !== 9'd360) $display("FAIL spacing3 got %0d want 360", mv.y); else passed++;
        total++; if (overrun !== 1'b1) $display("FAIL overrun_sticky got %b want 1", overrun); else passed++;
        propose(10'd600, 9'd380, 2'd0);  // in CHECK
        step();                          // in COMMIT
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if ({mv.x, mv.y, mv.dir_out} !== {10'd600, 9'd320, 2'd1})
            $display("FAIL reset_commit got %0d,%0d,%0d want 600,320,1", mv.x, mv.y, mv.dir_out); else passed++;
        total++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else passed++;
        step(); step();
        total++; if (mv.y !== 9'd320) $display("FAIL reset_nocommit got %0d want 320", mv.y); else passed++;
    endtask

    initial begin
        mv.move_tick = 1'b0; mv.next_x = '0; mv.next_y = '0; mv.ghost_direction = 2'd0;
        pacman_x = 10'd0; pacman_y = 9'd0; walls = '0;
        test_reset();
        test_accept();
        test_wall();
        test_bounds();
        test_catch_respawn();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ghost_position_commit.md
# ghost_position_commit

Downstream stage of each ghost movement controller: latches the controller's proposed `next_x`/`next_y` on a movement tick, validates it against the tile wall map and playfield bounds, and commits it to the registered ghost position fed back as the controller's `x`/`y`. It also detects ghost/Pac-Man contact, runs a respawn hold, and returns the ghost to its home tile.

## Interface
- `TILE_SIZE`, 20: tile edge in pixels.
- `COLS`, 32: tile columns (`tile_col_num`).
- `ROWS`, 24: tile rows (`tile_row_num`).
- `START_X`, 600: home x, pixels.
- `START_Y`, 320: home y, pixels.
- `RESPAWN_TICKS`, 60: move ticks spent in respawn hold, 1..255.
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `move_tick`  in  1  one-cycle pulse requesting one step.
- `next_x`  in  $clog2(`WIDTH`)  proposed x from ghost controller.
- `next_y`  in  $clog2(`HEIGHT`)  proposed y from ghost controller.
- `ghost_direction`  in  2  controller direction (`dir_*` encoding).
- `pacman_x`  in  $clog2(`WIDTH`)  current Pac-Man x.
- `pacman_y`  in  $clog2(`HEIGHT`)  current Pac-Man y.
- `tilemap_walls`  in  ROWS*COLS  wall bit per tile, index row*COLS+col, 1 = wall.
- `x`  out  $clog2(`WIDTH`)  committed ghost x.
- `y`  out  $clog2(`HEIGHT`)  committed ghost y.
- `dir_out`  out  2  direction of last committed step.
- `blocked`  out  1  one-cycle pulse: proposal rejected.
- `caught`  out  1  one-cycle pulse: contact with Pac-Man.
- `respawning`  out  1  high during respawn hold.
- `tick_overrun`  out  1  sticky: a tick arrived while busy.

## Operation
- States: IDLE, CHECK, COMMIT, RESPAWN.
- IDLE: on `move_tick`, register `next_x`, `next_y`, `ghost_direction` into proposal regs; go CHECK. Without tick, stay.
- CHECK: compute col = prop_x / TILE_SIZE, row = prop_y / TILE_SIZE. Reject if prop_x or prop_y not a multiple of TILE_SIZE, col ≥ COLS, row ≥ ROWS, or wall bit set. Reject → pulse `blocked`, x/y/dir_out unchanged, return IDLE. Accept → COMMIT.
- COMMIT: x ← prop_x, y ← prop_y, dir_out ← prop_dir; return IDLE.
- Contact check (IDLE only, every cycle): if x==pacman_x and y==pacman_y → pulse `caught`, load respawn counter with RESPAWN_TICKS, go RESPAWN. Contact outranks a simultaneous `move_tick` (tick discarded, not counted as overrun).
- RESPAWN: `respawning`=1; x/y frozen; each `move_tick` decrements counter. When a tick takes counter to 0: x ← START_X, y ← START_Y, dir_out ← `dir_down`, go IDLE. Ticks in RESPAWN are not overruns.
- `tick_overrun` sets when `move_tick` is high in CHECK or COMMIT; that tick is dropped. Cleared only by reset.
- Division by TILE_SIZE must be exact for in-range values (0..WIDTH-1); constant divider or compare chain acceptable, single-cycle combinational in CHECK.

## Timing
- Reset (synchronous, priority over all): state IDLE, x=START_X, y=START_Y, dir_out=`dir_down`, blocked=0, caught=0, respawning=0, tick_overrun=0, counter=0.
- Tick in cycle T (IDLE) → CHECK in T+1 → accepted: x/y visible T+3 (registered at end of COMMIT, T+2); rejected: `blocked` high in T+2, back in IDLE T+2.
- Minimum accepted tick spacing 3 cycles; 2 cycles after a rejection.
- `caught` high exactly one cycle, the cycle after contact is sampled; `respawning` rises same cycle.
- `respawning` falls the cycle the home position appears on x/y.
- Reset asserted mid-CHECK/COMMIT/RESPAWN: proposal discarded, outputs to reset values next edge.

## Test plan
- Reset, tick with next=(600,340), no walls → x/y=(600,340) at T+3, dir_out=`dir_down`, blocked=0.
- Wall at row 17 col 30 (bit 17*32+30=574), tick with next=(600,340) → blocked pulse at T+2, x/y stay (600,320).
- Tick with next=(610,320) and separately (640,320) → both blocked; also (0,480) → blocked.
- Ghost at (600,340), pacman_x/y set to (600,340) with simultaneous tick → caught one cycle, respawning=1, tick ignored, tick_overrun=0; RESPAWN_TICKS=3, three ticks → x/y=(600,320), respawning=0.
- Ticks on consecutive cycles → second dropped, tick_overrun=1 and stays 1 until reset; reset asserted during COMMIT → x/y=(600,320), no commit.
